// File: rtl/mem_access_unit_pkg.sv
// Shared types for the data-RAM initiator: word/address widths, access size
// encoding and the alignment rule used when a request is accepted.
package mem_access_unit_pkg;

    localparam int WORD_W     = 32;
    localparam int RAM_ADDR_W = 16;

    typedef logic [WORD_W-1:0]     Word;
    typedef logic [RAM_ADDR_W-1:0] RamAddress;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } MemSize;

    // Bytes never misalign; halves need addr[0]=0; words need addr[1:0]=0.
    function automatic logic is_misaligned(input MemSize size, input logic [1:0] lo);
        logic mis;
        case (size)
            MEM_BYTE: mis = 1'b0;
            MEM_HALF: mis = lo[0];
            default:  mis = |lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane handling shared by the load and merge paths: extracts and
// extends a load value, and builds a merged store word from the current RAM word.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  Word        word_i,
    input  logic [1:0] addr_i,
    input  MemSize     size_i,
    input  logic       unsigned_i,
    input  Word        store_data_i,
    output Word        load_o,
    output Word        merged_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [3:0]  lane_sel;
    Word         store_lanes;

    always_comb begin
        byte_lane   = word_i[{addr_i, 3'b000} +: 8];
        half_lane   = addr_i[1] ? word_i[31:16] : word_i[15:0];
        load_o      = word_i;
        lane_sel    = 4'b1111;
        store_lanes = store_data_i;
        case (size_i)
            MEM_BYTE: begin
                load_o      = {{24{~unsigned_i & byte_lane[7]}}, byte_lane};
                lane_sel    = 4'b0001 << addr_i;
                store_lanes = {4{store_data_i[7:0]}};
            end
            MEM_HALF: begin
                load_o      = {{16{~unsigned_i & half_lane[15]}}, half_lane};
                lane_sel    = addr_i[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Store data is replicated across all lanes so each byte lane only
    // has to choose between the new value and the word read from RAM.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_o[8*gi +: 8] = lane_sel[gi] ? store_lanes[8*gi +: 8]
                                                      : word_i[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Initiator for the word-wide data RAM: accepts byte/half/word loads and stores,
// extends loads, performs read-modify-write for sub-word stores, flags misalignment.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      req_valid,
    output logic      req_ready,
    input  logic      req_write,
    input  MemSize    req_size,
    input  logic      req_unsigned,
    input  RamAddress req_address,
    input  Word       req_data,
    output logic      resp_valid,
    input  logic      resp_ready,
    output Word       resp_data,
    output logic      resp_error,
    output logic      ram_write_enable,
    output RamAddress ram_address,
    output Word       ram_in,
    input  Word       ram_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MERGE,
        S_STORE,
        S_RESP
    } state_t;

    state_t    state_q, state_d;
    RamAddress addr_q, addr_d;
    MemSize    size_q, size_d;
    logic      unsigned_q, unsigned_d;
    Word       sdata_q, sdata_d;
    Word       wbuf_q, wbuf_d;
    Word       rdata_q, rdata_d;
    logic      rerr_q, rerr_d;

    logic      store_phase;
    Word       load_value;
    Word       merged_word;
    RamAddress word_addr;

    assign word_addr = {addr_q[RAM_ADDR_W-1:2], 2'b00};

    mem_lane_align u_align (
        .word_i       (ram_out),
        .addr_i       (addr_q[1:0]),
        .size_i       (size_q),
        .unsigned_i   (unsigned_q),
        .store_data_i (sdata_q),
        .load_o       (load_value),
        .merged_o     (merged_word)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        sdata_d     = sdata_q;
        wbuf_d      = wbuf_q;
        rdata_d     = rdata_q;
        rerr_d      = rerr_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        ram_address = '0;
        ram_in      = '0;
        store_phase = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d     = req_address;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    sdata_d    = req_data;
                    rdata_d    = '0;
                    rerr_d     = is_misaligned(req_size, req_address[1:0]);
                    if (is_misaligned(req_size, req_address[1:0])) begin
                        state_d = S_RESP;
                    end else if (!req_write) begin
                        state_d = S_LOAD;
                    end else if (req_size == MEM_WORD) begin
                        wbuf_d  = req_data;
                        state_d = S_STORE;
                    end else begin
                        state_d = S_MERGE;
                    end
                end
            end
            S_LOAD: begin
                ram_address = word_addr;
                rdata_d     = load_value;
                state_d     = S_RESP;
            end
            S_MERGE: begin
                ram_address = word_addr;
                wbuf_d      = merged_word;
                state_d     = S_STORE;
            end
            S_STORE: begin
                ram_address = word_addr;
                ram_in      = wbuf_q;
                store_phase = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Gated by rst_n so a reset landing on the STORE cycle never reaches the RAM.
    assign ram_write_enable = store_phase && rst_n;
    assign resp_data        = rdata_q;
    assign resp_error       = rerr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            size_q     <= MEM_BYTE;
            unsigned_q <= 1'b0;
            sdata_q    <= '0;
            wbuf_q     <= '0;
            rdata_q    <= '0;
            rerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            sdata_q    <= sdata_d;
            wbuf_q     <= wbuf_d;
            rdata_q    <= rdata_d;
            rerr_q     <= rerr_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, multi-cycle corner sequences,
// and random traffic checked against a byte-addressed memory model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n = 1'b0;
    logic      req_valid = 1'b0;
    logic      req_ready;
    logic      req_write = 1'b0;
    MemSize    req_size = MEM_BYTE;
    logic      req_unsigned = 1'b0;
    RamAddress req_address = '0;
    Word       req_data = '0;
    logic      resp_valid;
    logic      resp_ready = 1'b1;
    Word       resp_data;
    logic      resp_error;
    logic      ram_write_enable;
    RamAddress ram_address;
    Word       ram_in;
    Word       ram_out;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_address      (req_address),
        .req_data         (req_data),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .resp_error       (resp_error),
        .ram_write_enable (ram_write_enable),
        .ram_address      (ram_address),
        .ram_in           (ram_in),
        .ram_out          (ram_out)
    );

    // RAM model: combinational read, write on posedge
    Word  mem [0:255];
    int   wr_count = 0;
    logic clear_mem = 1'b1;
    assign ram_out = mem[ram_address[9:2]];
    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (ram_write_enable) begin
            mem[ram_address[9:2]] <= ram_in;
            wr_count <= wr_count + 1;
        end
    end

    // Reference: plain byte-addressed memory
    logic [7:0] ref_bytes [0:1023];
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    function automatic bit ref_misaligned(input int addr, input int sz);
        return (addr % (1 << sz)) != 0;
    endfunction

    function automatic Word ref_load(input int addr, input int sz, input bit uns);
        int n;
        longint v;
        n = 1 << sz;
        v = 0;
        for (int i = 0; i < n; i++) v = v + (longint'(ref_bytes[addr + i]) << (8 * i));
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return Word'(v);
    endfunction

    task automatic ref_store(input int addr, input int sz, input Word data);
        for (int i = 0; i < (1 << sz); i++) ref_bytes[addr + i] = data[8*i +: 8];
    endtask

    function automatic Word ref_word(input int waddr);
        return {ref_bytes[waddr + 3], ref_bytes[waddr + 2], ref_bytes[waddr + 1], ref_bytes[waddr]};
    endfunction

    task automatic do_req(input logic wr, input MemSize sz, input logic uns, input logic [15:0] addr,
                          input Word data, input int hold,
                          output Word rd, output logic re, output int lat, output int nwr);
        int w0;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_address  = addr;
        req_data     = data;
        resp_ready   = (hold == 0);
        w0 = wr_count;
        @(posedge clk);
        #1;
        // scramble request fields: only latched values may matter
        req_valid    = 1'b0;
        req_write    = 1'($urandom);
        req_size     = MemSize'($urandom_range(0, 2));
        req_unsigned = 1'($urandom);
        req_address  = 16'($urandom);
        req_data     = $urandom;
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!resp_valid) check("resp_timeout", 0, 1);
        rd = resp_data;
        re = resp_error;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_resp_valid", resp_valid, 1);
            check("hold_resp_data", resp_data, rd);
            check("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("resp_drop", resp_valid, 0);
        nwr = wr_count - w0;
    endtask

    typedef struct {
        logic        wr;
        MemSize      sz;
        logic        uns;
        logic [15:0] addr;
        Word         data;
        Word         exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [17];

    initial begin
        Word  rd;
        logic re;
        int   lat, nwr, w0;

        vecs[0]  = '{1'b1, MEM_WORD, 1'b0, 16'h0010, 32'hDEADBEEF, 32'h00000000, 1'b0, 2};
        vecs[1]  = '{1'b0, MEM_WORD, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 2};
        vecs[2]  = '{1'b1, MEM_WORD, 1'b0, 16'h0020, 32'h11223344, 32'h00000000, 1'b0, 2};
        vecs[3]  = '{1'b1, MEM_BYTE, 1'b0, 16'h0021, 32'h000000AA, 32'h00000000, 1'b0, 3};
        vecs[4]  = '{1'b0, MEM_WORD, 1'b0, 16'h0020, 32'h0,        32'h1122AA44, 1'b0, 2};
        vecs[5]  = '{1'b1, MEM_WORD, 1'b0, 16'h0030, 32'h80FF7F01, 32'h00000000, 1'b0, 2};
        vecs[6]  = '{1'b0, MEM_BYTE, 1'b0, 16'h0032, 32'h0,        32'hFFFFFFFF, 1'b0, 2};
        vecs[7]  = '{1'b0, MEM_BYTE, 1'b1, 16'h0032, 32'h0,        32'h000000FF, 1'b0, 2};
        vecs[8]  = '{1'b0, MEM_HALF, 1'b0, 16'h0030, 32'h0,        32'h00007F01, 1'b0, 2};
        vecs[9]  = '{1'b0, MEM_HALF, 1'b0, 16'h0032, 32'h0,        32'hFFFF80FF, 1'b0, 2};
        vecs[10] = '{1'b1, MEM_HALF, 1'b0, 16'h0013, 32'h00005555, 32'h00000000, 1'b1, 1};
        vecs[11] = '{1'b0, MEM_WORD, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 2};
        vecs[12] = '{1'b0, MEM_WORD, 1'b0, 16'h0002, 32'h0,        32'h00000000, 1'b1, 1};
        vecs[13] = '{1'b1, MEM_HALF, 1'b0, 16'h0012, 32'h1234BEEF, 32'h00000000, 1'b0, 3};
        vecs[14] = '{1'b0, MEM_WORD, 1'b0, 16'h0010, 32'h0,        32'hBEEFBEEF, 1'b0, 2};
        vecs[15] = '{1'b0, MEM_HALF, 1'b1, 16'h0012, 32'h0,        32'h0000BEEF, 1'b0, 2};
        vecs[16] = '{1'b0, MEM_BYTE, 1'b0, 16'h0013, 32'h0,        32'hFFFFFFBE, 1'b0, 2};

        for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'h00;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_error", resp_error, 0);
        check("rst_ram_we", ram_write_enable, 0);
        rst_n = 1'b1;
        clear_mem = 1'b0;

        // directed vector table
        for (int i = 0; i < 17; i++) begin
            do_req(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].data, 0, rd, re, lat, nwr);
            $display("vec %0d wr=%0d sz=%0d addr=%04h data=%08h err=%0d lat=%0d writes=%0d",
                     i, vecs[i].wr, vecs[i].sz, vecs[i].addr, rd, re, lat, nwr);
            check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
            check($sformatf("vec%0d_error", i), re, vecs[i].exp_err);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_writes", i), nwr, (vecs[i].wr && !vecs[i].exp_err) ? 1 : 0);
            if (vecs[i].wr && !vecs[i].exp_err) ref_store(vecs[i].addr, vecs[i].sz, vecs[i].data);
        end
        check("ram_word_20_merged", mem[8'h08], 32'h1122AA44);
        check("ram_word_10_final", mem[8'h04], 32'hBEEFBEEF);

        // response held off for 5 cycles
        do_req(1'b0, MEM_WORD, 1'b0, 16'h0030, 32'h0, 5, rd, re, lat, nwr);
        $display("hold load addr=0030 data=%08h err=%0d lat=%0d", rd, re, lat);
        check("hold_load_data", rd, 32'h80FF7F01);

        // reset asserted in the STORE cycle of a byte store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = MEM_BYTE;
        req_unsigned = 1'b0; req_address = 16'h0041; req_data = 32'h00000077;
        w0 = wr_count;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst_store_phase_we", ram_write_enable, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_we_suppressed", ram_write_enable, 0);
        @(posedge clk); #1;
        check("midrst_req_ready", req_ready, 1);
        check("midrst_resp_valid", resp_valid, 0);
        check("midrst_writes", wr_count - w0, 0);
        check("midrst_ram_word_40", mem[8'h10], ref_word(16'h0040));
        $display("midop reset byte store addr=0041 writes=%0d", wr_count - w0);
        @(negedge clk);
        rst_n = 1'b1;

        // randomized traffic against the reference model
        for (int t = 0; t < 60; t++) begin
            logic   wr, uns, exp_err;
            MemSize sz;
            int     addr, exp_lat;
            Word    data, exp_data;
            wr   = 1'($urandom);
            uns  = 1'($urandom);
            sz   = MemSize'($urandom_range(0, 2));
            addr = $urandom_range(0, 255);
            data = $urandom;
            exp_err  = ref_misaligned(addr, int'(sz));
            exp_data = (wr || exp_err) ? 32'h0 : ref_load(addr, int'(sz), uns);
            exp_lat  = exp_err ? 1 : (!wr || sz == MEM_WORD) ? 2 : 3;
            do_req(wr, sz, uns, 16'(addr), data, 0, rd, re, lat, nwr);
            $display("rnd %0d wr=%0d sz=%0d uns=%0d addr=%04h data=%08h err=%0d lat=%0d writes=%0d",
                     t, wr, sz, uns, addr, rd, re, lat, nwr);
            check("rnd_data", rd, exp_data);
            check("rnd_error", re, exp_err);
            check("rnd_latency", lat, exp_lat);
            check("rnd_writes", nwr, (wr && !exp_err) ? 1 : 0);
            if (wr && !exp_err) ref_store(addr, int'(sz), data);
        end

        for (int w = 0; w < 64; w++) check($sformatf("ram_word_%02h", 4 * w), mem[w], ref_word(4 * w));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d required=0", 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

endmodule
